// File: rtl/exprnd_pipe_pkg.sv
// fpu_rnd_pkg: shared types and exponent constants for the rounder back end
package fpu_rnd_pkg;
  typedef enum logic [1:0] {RM_RZ, RM_RNE, RM_RU, RM_RD} rm_t;
  typedef struct packed {logic ovf; logic unf; logic inx;} exc_flags_t;
  function automatic int emax(input int ew);
    return (1 << ew) - 2;
  endfunction
  function automatic int alpha(input int ew);
    return 3 << (ew - 2);
  endfunction
endpackage

// File: rtl/exprnd_pipe_if.sv
// exprnd_pipe_if: valid/ready beat bus, trap enables and sticky flag access for exprnd_pipe
interface exprnd_pipe_if import fpu_rnd_pkg::*; #(parameter int EXP_W = 11, parameter int FRAC_W = 52);
  logic                    in_valid, in_ready, in_s, in_inx, ovf_en, unf_en;
  logic signed [EXP_W+1:0] in_e;
  logic [FRAC_W:0]         in_f;
  rm_t                     in_rm;
  logic                    out_valid, out_ready, out_s, flags_clr;
  logic [EXP_W-1:0]        out_e;
  logic [FRAC_W-1:0]       out_f;
  logic [1:0]              out_trap;
  exc_flags_t              flags;
  modport master (output in_valid, in_s, in_e, in_f, in_rm, in_inx, ovf_en, unf_en, out_ready, flags_clr,
                  input  in_ready, out_valid, out_s, out_e, out_f, out_trap, flags);
  modport slave  (input  in_valid, in_s, in_e, in_f, in_rm, in_inx, ovf_en, unf_en, out_ready, flags_clr,
                  output in_ready, out_valid, out_s, out_e, out_f, out_trap, flags);
endinterface

// File: rtl/exprnd_pipe_core.sv
// exprnd_core: classify the exponent, resolve overflow/underflow and trap wrapping, pack fields
module exprnd_core import fpu_rnd_pkg::*; #(parameter int EXP_W = 11, parameter int FRAC_W = 52) (
  input  logic                    s_i,
  input  logic signed [EXP_W+1:0] e_i,
  input  logic [FRAC_W:0]         f_i,
  input  rm_t                     rm_i,
  input  logic                    inx_i,
  input  logic                    ovf_en_i,
  input  logic                    unf_en_i,
  output logic [EXP_W-1:0]        e_o,
  output logic [FRAC_W-1:0]       f_o,
  output logic [1:0]              trap_o,
  output exc_flags_t              new_o
);
  localparam int EW2 = EXP_W + 2;
  localparam logic signed [EXP_W+1:0] EMAX = EW2'(emax(EXP_W));
  localparam logic [EXP_W-1:0] EMAX_L = EXP_W'(emax(EXP_W));
  localparam logic [EXP_W-1:0] ALPHA = EXP_W'(alpha(EXP_W));
  logic [1:0] rm;
  logic ovf, tiny, inf_sel, sat;
  // Classify and select the packed result; wrapped exponents only need the low EXP_W bits
  always_comb begin
    rm = rm_i;
    ovf = e_i > EMAX;
    tiny = e_i[EXP_W+1] | ~|e_i | ~f_i[FRAC_W];
    inf_sel = rm[1] ? ~(rm[0] ^ s_i) : rm[0];
    sat = ovf & ~ovf_en_i;
    e_o = ovf ? (ovf_en_i ? e_i[EXP_W-1:0] - ALPHA : inf_sel ? {EXP_W{1'b1}} : EMAX_L)
        : tiny ? (unf_en_i ? e_i[EXP_W-1:0] + ALPHA : '0) : e_i[EXP_W-1:0];
    f_o = sat ? (inf_sel ? '0 : {FRAC_W{1'b1}}) : f_i[FRAC_W-1:0];
    trap_o = {ovf & ovf_en_i, tiny & unf_en_i & ~ovf};
    new_o.ovf = ovf;
    new_o.unf = tiny & ~ovf & (unf_en_i | inx_i);
    new_o.inx = inx_i | sat;
  end
endmodule

// File: rtl/exprnd_pipe.sv
// exprnd_pipe: two-stage exponent adjust and pack with valid/ready handshake and sticky flags
module exprnd_pipe import fpu_rnd_pkg::*; #(parameter int EXP_W = 11, parameter int FRAC_W = 52) (
  input logic           clk,
  input logic           rst,
  exprnd_pipe_if.slave  bus
);
  logic                    s1_valid_q, s1_s_q, s1_inx_q, s1_oen_q, s1_uen_q;
  logic signed [EXP_W+1:0] s1_e_q;
  logic [FRAC_W:0]         s1_f_q;
  rm_t                     s1_rm_q;
  logic                    s2_valid_q, s2_s_q;
  logic [EXP_W-1:0]        s2_e_q, s2_e_d;
  logic [FRAC_W-1:0]       s2_f_q, s2_f_d;
  logic [1:0]              s2_trap_q, s2_trap_d;
  exc_flags_t              flags_q, flags_d, new_flags;
  logic                    adv2, load2;
  assign adv2 = ~s2_valid_q | bus.out_ready;
  assign load2 = adv2 & s1_valid_q;
  assign bus.in_ready = adv2 | ~s1_valid_q;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_s = s2_s_q;
  assign bus.out_e = s2_e_q;
  assign bus.out_f = s2_f_q;
  assign bus.out_trap = s2_trap_q;
  assign bus.flags = flags_q;
  exprnd_core #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_core (
    .s_i(s1_s_q), .e_i(s1_e_q), .f_i(s1_f_q), .rm_i(s1_rm_q), .inx_i(s1_inx_q),
    .ovf_en_i(s1_oen_q), .unf_en_i(s1_uen_q),
    .e_o(s2_e_d), .f_o(s2_f_d), .trap_o(s2_trap_d), .new_o(new_flags)
  );
  // Sticky flags: a clear drops old bits, but a beat loading in the same cycle still sets its own
  always_comb flags_d = (flags_q & ~{3{bus.flags_clr}}) | (load2 ? new_flags : '0);
  // S1 input register, including the per-beat trap enables and rounding mode
  always_ff @(posedge clk)
    if (rst) begin
      s1_valid_q <= 1'b0;
      {s1_s_q, s1_e_q, s1_f_q, s1_inx_q, s1_oen_q, s1_uen_q} <= '0;
      s1_rm_q <= RM_RZ;
    end else if (bus.in_ready) begin
      s1_valid_q <= bus.in_valid;
      s1_s_q <= bus.in_s;
      s1_e_q <= bus.in_e;
      s1_f_q <= bus.in_f;
      s1_rm_q <= bus.in_rm;
      s1_inx_q <= bus.in_inx;
      s1_oen_q <= bus.ovf_en;
      s1_uen_q <= bus.unf_en;
    end
  // S2 output register and flag state; holds while the consumer stalls
  always_ff @(posedge clk)
    if (rst) begin
      s2_valid_q <= 1'b0;
      {s2_s_q, s2_e_q, s2_f_q, s2_trap_q} <= '0;
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
      if (adv2) s2_valid_q <= s1_valid_q;
      if (load2) {s2_s_q, s2_e_q, s2_f_q, s2_trap_q} <= {s1_s_q, s2_e_d, s2_f_d, s2_trap_d};
    end
endmodule
